hms_alarm_core: RTL
===================

Name: hms_alarm_core

Overview:
- Parametrised hour:min:sec timekeeper with an internal prescaler, setup and alarm editing, NUM_ALARMS independent alarms, and a ring state machine.
- Single clock domain. The 1 Hz advance is a clock-enable pulse, not a derived clock.
- Sits between the debounced switch controller (single-cycle pulses) and the display/buzzer path.
- Successor to the fixed min:sec, single-alarm clock: adds hours, inc/dec, multiple alarms, ring timeout and ack.

Parameters:
- CLK_HZ, 50000000, clk cycles per second tick; must be ≥2.
- NUM_ALARMS, 2, number of alarm slots, 1..8.
- RING_SEC, 30, ticks the ring lasts before self-clear, 1..63.
- SNOOZE_SEC, 10, ticks spent snoozing, 1..63; used only with HMS_SNOOZE_EN.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- i_mode  in  2  0 CLOCK, 1 SETUP, 2 ALARM, 3 treated as CLOCK.
- i_pos  in  2  0 sec, 1 min, 2 hour, 3 none.
- i_alarm_sel  in  3  alarm slot edited/displayed in ALARM mode; values ≥NUM_ALARMS are ignored.
- i_inc  in  1  single-cycle increment pulse.
- i_dec  in  1  single-cycle decrement pulse.
- i_alarm_en  in  NUM_ALARMS  per-slot enable (level).
- i_ack  in  1  pulse, stops ringing.
- i_snooze  in  1  pulse, snooze request; ignored without the macro.
- o_sec  out  6  displayed seconds.
- o_min  out  6  displayed minutes.
- o_hour  out  5  displayed hours.
- o_tick  out  1  one-cycle pulse, high in the cycle the time fields show the new value.
- o_ring  out  1  high while ringing; drives buzzer enable.
- o_ring_id  out  3  slot that caused the current ring.

Behaviour:
- Reset, sampled on posedge clk with rst_n=0:
  - Prescaler, time, all alarm fields, and ring/snooze counters go to 0.
  - FSM goes to IDLE.
  - All outputs are 0.
- Prescaler:
  - Counts 0..CLK_HZ-1. At CLK_HZ-1 it wraps to 0 and generates the tick.
  - Held at 0 in SETUP mode.
- Timekeeping (CLOCK/ALARM modes), on tick:
  - sec 0..59; wrap carries to min 0..59; wrap carries to hour 0..23.
  - 23:59:59 → 00:00:00.
  - Update and o_tick occur on the same edge. Latency is CLK_HZ cycles from leaving reset to the first tick.
- SETUP mode:
  - No ticks.
  - i_inc/i_dec adjust the field selected by i_pos with modulo wrap and no carry: sec 59→0, 0→59; hour 23→0.
  - Any edit of sec also clears the prescaler.
- ALARM mode:
  - Time keeps running.
  - i_inc/i_dec adjust the i_pos field of alarm[i_alarm_sel], same wrap rules.
  - Display shows that alarm.
- Edit conflicts: i_inc and i_dec in the same cycle give no change. i_pos=3 or an invalid sel gives no change.
- Display mux:
  - CLOCK and SETUP show time.
  - ALARM shows alarm[i_alarm_sel], or time if sel is invalid.
  - Combinational from registers.
- Match:
  - Evaluated only in the o_tick cycle: new time == alarm[k] and i_alarm_en[k].
  - The lowest matching k wins.
  - Manual editing onto an alarm time never triggers.
- Ring FSM states: IDLE, RING, SNOOZE.
  - IDLE → RING on the edge after a match. o_ring rises 1 cycle after o_tick; o_ring_id=k; ring counter cleared.
  - RING:
    - The ring counter increments on each tick.
    - At RING_SEC ticks, go to IDLE.
    - i_ack goes to IDLE next edge.
    - Deasserting i_alarm_en[o_ring_id] goes to IDLE next edge.
    - Matches from other slots while ringing are ignored.
  - In SETUP no ticks occur, so the ring counter freezes; ack still works.
  - Mode changes never alter FSM state.
  - If i_ack and a match occur in the same cycle, ack wins and the FSM goes to IDLE.
- o_ring_id holds its last value in IDLE.

Optional Feature:
- HMS_SNOOZE_EN defined:
  - In RING, i_snooze moves to SNOOZE with o_ring=0 and the snooze counter cleared.
  - After SNOOZE_SEC ticks, return to RING with the ring counter cleared and the same o_ring_id.
  - i_ack or a disabled slot in SNOOZE goes to IDLE.
  - If i_ack and i_snooze arrive together, ack wins.
- Undefined:
  - SNOOZE state and snooze counter are not built.
  - i_snooze is unconnected/ignored.

Decomposition:
- Package hms_pkg holds:
  - Mode encodings.
  - Position encodings.
  - Ring state encodings.
  - Constants SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23.
- Sub-module hms_field: modulo-N register with tick-enable carry-in/carry-out plus inc/dec editing, parameter MAX and width.
  - Three instances for time.
  - Three per alarm slot, instances with carry disabled.

Test Plan (CLK_HZ=4, RING_SEC=3, SNOOZE_SEC=2):
- Rollover: SETUP, set 23:59:58 via dec presses, switch to CLOCK → after 4 cycles 23:59:59, after 8 cycles 00:00:00 with o_tick each time.
- Edit wrap: SETUP pos=0 at sec=0, i_dec → 59, min unchanged. Simultaneous i_inc+i_dec → unchanged.
- Alarm match: alarm1=00:00:02 enabled, alarm0 disabled → o_ring=1 one cycle after the tick showing 00:00:02, o_ring_id=1. Clears after 3 further ticks.
- Priority/ack: alarm0 and alarm1 both 00:00:05 enabled → o_ring_id=0. i_ack → o_ring=0 next cycle. No retrigger until next day.
- Disable and reset mid-ring: while ringing, drop i_alarm_en[id] → o_ring=0 next edge. Repeat with rst_n=0 for one cycle → all outputs 0, time 00:00:00.
- Snooze (macro on): ring, i_snooze → o_ring=0 for 2 ticks, then o_ring=1 again with the same id. Macro off: i_snooze has no effect.

Source files
------------

// File: rtl/hms_pkg.sv
// hms_pkg: shared encodings and limits for the hour:min:sec alarm clock.
//
// Contents:
//   mode_e        operating mode (CLOCK / SETUP / ALARM; code 3 behaves as CLOCK)
//   pos_e         edited field (sec / min / hour / none)
//   ring_state_e  ring state machine encoding (SNOOZE is only reachable
//                 when the core is built with HMS_SNOOZE_EN)
//   *_MAX, *_W    field limits and widths
package hms_pkg;

    typedef enum logic [1:0] {
        MODE_CLOCK     = 2'd0,
        MODE_SETUP     = 2'd1,
        MODE_ALARM     = 2'd2,
        MODE_CLOCK_ALT = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        POS_SEC  = 2'd0,
        POS_MIN  = 2'd1,
        POS_HOUR = 2'd2,
        POS_NONE = 2'd3
    } pos_e;

    typedef enum logic [1:0] {
        RS_IDLE   = 2'd0,
        RS_RING   = 2'd1,
        RS_SNOOZE = 2'd2
    } ring_state_e;

    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;

    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

endpackage

// File: rtl/hms_field.sv
// hms_field: one modulo-(MAX+1) time field.
//
// Ports:
//   clk    in   system clock
//   rst_n  in   synchronous active-low reset (value -> 0)
//   tick   in   carry-in: advance by one, wrapping MAX -> 0
//   inc    in   edit pulse: +1 with wrap, no carry-out
//   dec    in   edit pulse: -1 with wrap, no carry-out
//   value  out  current field value
//   carry  out  high when tick wraps the field (feeds the next field's tick)
//
// inc and dec together cancel. tick takes precedence over editing; the top
// level never asserts both in the same cycle for one field.
module hms_field #(
    parameter int MAX = 59,
    parameter int W   = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tick,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] value,
    output logic         carry
);

    logic at_max;
    logic at_zero;

    assign at_max  = (value == W'(MAX));
    assign at_zero = (value == '0);
    assign carry   = tick && at_max;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, independent of block order.
    // NOTE: alarm slots are built from this same register and are cleared by
    // reset as well, so an unprogrammed alarm reads 00:00:00, never X.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value <= '0;
        end else if (tick) begin
            value <= at_max ? '0 : value + W'(1);
        end else if (inc && !dec) begin
            value <= at_max ? '0 : value + W'(1);
        end else if (dec && !inc) begin
            value <= at_zero ? W'(MAX) : value - W'(1);
        end
    end

endmodule

// File: rtl/hms_alarm_core.sv
// hms_alarm_core: hour:min:sec timekeeper with prescaler, setup/alarm editing,
// NUM_ALARMS alarm slots and a ring state machine.
//
// Build option: define HMS_SNOOZE_EN to add the SNOOZE state and its counter.
// Without it i_snooze is ignored.
//
// Ports:
//   clk          in   system clock (single domain; 1 Hz is a clock enable)
//   rst_n        in   synchronous active-low reset
//   i_mode       in   0 CLOCK, 1 SETUP, 2 ALARM, 3 as CLOCK
//   i_pos        in   field to edit: 0 sec, 1 min, 2 hour, 3 none
//   i_alarm_sel  in   alarm slot edited/displayed in ALARM mode
//   i_inc/i_dec  in   single-cycle edit pulses (together = no change)
//   i_alarm_en   in   per-slot alarm enable (level)
//   i_ack        in   pulse, stops ringing
//   i_snooze     in   pulse, snooze request (HMS_SNOOZE_EN only)
//   o_sec/o_min/o_hour  out  displayed time or selected alarm
//   o_tick       out  high in the cycle the time fields show a new second
//   o_ring       out  buzzer enable
//   o_ring_id    out  slot that caused the current/last ring
module hms_alarm_core
    import hms_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int NUM_ALARMS = 2,
    parameter int RING_SEC   = 30,
    parameter int SNOOZE_SEC = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            i_mode,
    input  logic [1:0]            i_pos,
    input  logic [2:0]            i_alarm_sel,
    input  logic                  i_inc,
    input  logic                  i_dec,
    input  logic [NUM_ALARMS-1:0] i_alarm_en,
    input  logic                  i_ack,
    input  logic                  i_snooze,
    output logic [5:0]            o_sec,
    output logic [5:0]            o_min,
    output logic [4:0]            o_hour,
    output logic                  o_tick,
    output logic                  o_ring,
    output logic [2:0]            o_ring_id
);

    localparam int PW      = $clog2(CLK_HZ);
    localparam int TMR_MAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
    localparam int CNT_W   = $clog2(TMR_MAX + 1);

    mode_e mode;
    pos_e  pos;
    logic  is_setup;
    logic  is_alarm;

    assign mode     = mode_e'(i_mode);
    assign pos      = pos_e'(i_pos);
    assign is_setup = (mode == MODE_SETUP);
    assign is_alarm = (mode == MODE_ALARM);

    // ------------------------------------------------------------------
    // Prescaler. Held at 0 in SETUP, which also covers "editing seconds
    // restarts the second": the first tick after SETUP is a full second away.
    // ------------------------------------------------------------------
    logic [PW-1:0] presc;
    logic          tick;
    logic          tick_q;

    assign tick = !is_setup && (presc == PW'(CLK_HZ - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc  <= '0;
            tick_q <= 1'b0;
        end else begin
            presc  <= (is_setup || tick) ? '0 : presc + PW'(1);
            // Registered so o_tick lines up with the fields' new value.
            tick_q <= tick;
        end
    end

    assign o_tick = tick_q;

    // ------------------------------------------------------------------
    // Time fields: sec -> min -> hour carry chain; edited only in SETUP.
    // ------------------------------------------------------------------
    logic [SEC_W-1:0]  t_sec;
    logic [MIN_W-1:0]  t_min;
    logic [HOUR_W-1:0] t_hour;
    logic              c_sec;
    logic              c_min;
    logic              unused_c_hour;

    hms_field #(.MAX(SEC_MAX), .W(SEC_W)) u_t_sec (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick),
        .inc   (i_inc && is_setup && pos == POS_SEC),
        .dec   (i_dec && is_setup && pos == POS_SEC),
        .value (t_sec),
        .carry (c_sec)
    );

    hms_field #(.MAX(MIN_MAX), .W(MIN_W)) u_t_min (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (c_sec),
        .inc   (i_inc && is_setup && pos == POS_MIN),
        .dec   (i_dec && is_setup && pos == POS_MIN),
        .value (t_min),
        .carry (c_min)
    );

    hms_field #(.MAX(HOUR_MAX), .W(HOUR_W)) u_t_hour (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (c_min),
        .inc   (i_inc && is_setup && pos == POS_HOUR),
        .dec   (i_dec && is_setup && pos == POS_HOUR),
        .value (t_hour),
        .carry (unused_c_hour)
    );

    // ------------------------------------------------------------------
    // Alarm slots: same field register with the carry chain tied off.
    // ------------------------------------------------------------------
    logic [SEC_W-1:0]  alm_sec  [NUM_ALARMS];
    logic [MIN_W-1:0]  alm_min  [NUM_ALARMS];
    logic [HOUR_W-1:0] alm_hour [NUM_ALARMS];

    for (genvar k = 0; k < NUM_ALARMS; k++) begin : g_alarm
        logic sel_here;
        logic unused_c_sec;
        logic unused_c_min;
        logic unused_c_hr;

        assign sel_here = is_alarm && (i_alarm_sel == 3'(k));

        hms_field #(.MAX(SEC_MAX), .W(SEC_W)) u_a_sec (
            .clk   (clk),
            .rst_n (rst_n),
            .tick  (1'b0),
            .inc   (i_inc && sel_here && pos == POS_SEC),
            .dec   (i_dec && sel_here && pos == POS_SEC),
            .value (alm_sec[k]),
            .carry (unused_c_sec)
        );

        hms_field #(.MAX(MIN_MAX), .W(MIN_W)) u_a_min (
            .clk   (clk),
            .rst_n (rst_n),
            .tick  (1'b0),
            .inc   (i_inc && sel_here && pos == POS_MIN),
            .dec   (i_dec && sel_here && pos == POS_MIN),
            .value (alm_min[k]),
            .carry (unused_c_min)
        );

        hms_field #(.MAX(HOUR_MAX), .W(HOUR_W)) u_a_hour (
            .clk   (clk),
            .rst_n (rst_n),
            .tick  (1'b0),
            .inc   (i_inc && sel_here && pos == POS_HOUR),
            .dec   (i_dec && sel_here && pos == POS_HOUR),
            .value (alm_hour[k]),
            .carry (unused_c_hr)
        );
    end

    // ------------------------------------------------------------------
    // Display mux: the selected alarm in ALARM mode, time otherwise or
    // when the selection names a slot that does not exist.
    // ------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        o_sec  = t_sec;
        o_min  = t_min;
        o_hour = t_hour;
        if (is_alarm) begin
            for (int k = 0; k < NUM_ALARMS; k++) begin
                if (i_alarm_sel == 3'(k)) begin
                    o_sec  = alm_sec[k];
                    o_min  = alm_min[k];
                    o_hour = alm_hour[k];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Match: only in the o_tick cycle, so manual edits never trigger.
    // Scanning downwards lets the lowest matching slot win.
    // ------------------------------------------------------------------
    logic       match;
    logic [2:0] match_id;
    logic       cur_en;

    ring_state_e      state;
    ring_state_e      state_d;
    logic [CNT_W-1:0] ring_cnt;
    logic [CNT_W-1:0] ring_cnt_d;
    logic [2:0]       ring_id;
    logic [2:0]       ring_id_d;

    always_comb begin
        match    = 1'b0;
        match_id = '0;
        for (int k = NUM_ALARMS - 1; k >= 0; k--) begin
            if (tick_q && i_alarm_en[k] && alm_sec[k] == t_sec &&
                alm_min[k] == t_min && alm_hour[k] == t_hour) begin
                match    = 1'b1;
                match_id = 3'(k);
            end
        end
    end

    // Enable level of the slot currently ringing/snoozing.
    always_comb begin
        cur_en = 1'b0;
        for (int k = 0; k < NUM_ALARMS; k++) begin
            if (ring_id == 3'(k)) cur_en = i_alarm_en[k];
        end
    end

    // ------------------------------------------------------------------
    // Ring state machine
    // ------------------------------------------------------------------
`ifdef HMS_SNOOZE_EN
    logic [CNT_W-1:0] snz_cnt;
    logic [CNT_W-1:0] snz_cnt_d;
`else
    logic unused_snooze;
    assign unused_snooze = i_snooze;
`endif

    always_comb begin
        state_d    = state;
        ring_cnt_d = ring_cnt;
        ring_id_d  = ring_id;
`ifdef HMS_SNOOZE_EN
        snz_cnt_d  = snz_cnt;
`endif
        case (state)
            RS_IDLE: begin
                // A same-cycle ack suppresses a new ring.
                if (match && !i_ack) begin
                    state_d    = RS_RING;
                    ring_id_d  = match_id;
                    ring_cnt_d = '0;
                end
            end
            RS_RING: begin
                if (i_ack || !cur_en) begin
                    state_d = RS_IDLE;
`ifdef HMS_SNOOZE_EN
                end else if (i_snooze) begin
                    state_d   = RS_SNOOZE;
                    snz_cnt_d = '0;
`endif
                end else if (tick_q) begin
                    if (ring_cnt == CNT_W'(RING_SEC - 1)) state_d = RS_IDLE;
                    else ring_cnt_d = ring_cnt + CNT_W'(1);
                end
            end
`ifdef HMS_SNOOZE_EN
            RS_SNOOZE: begin
                if (i_ack || !cur_en) begin
                    state_d = RS_IDLE;
                end else if (tick_q) begin
                    if (snz_cnt == CNT_W'(SNOOZE_SEC - 1)) begin
                        state_d    = RS_RING;
                        ring_cnt_d = '0;
                    end else begin
                        snz_cnt_d = snz_cnt + CNT_W'(1);
                    end
                end
            end
`endif
            default: state_d = RS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= RS_IDLE;
            ring_cnt <= '0;
            ring_id  <= '0;
`ifdef HMS_SNOOZE_EN
            snz_cnt  <= '0;
`endif
        end else begin
            state    <= state_d;
            ring_cnt <= ring_cnt_d;
            ring_id  <= ring_id_d;
`ifdef HMS_SNOOZE_EN
            snz_cnt  <= snz_cnt_d;
`endif
        end
    end

    assign o_ring    = (state == RS_RING);
    assign o_ring_id = ring_id;

endmodule
